interleaver_seq_ctrl: RTL
=========================

Name: interleaver_seq_ctrl

Overview:
Sequencer for the turbo-coder interleaver datapath. It takes a start request and block size, then gates K/8 bytes into the 6144-bit input shift register. It waits a fixed settle time for the combinational remap network, then steps the 14-bit bit-select index shared by both output muxes (natural stream and remapped stream) through 0..K-1 under a valid/ready handshake. Block size is latched at start, so the datapath sees a stable K for the whole block.

Parameters:
K_LARGE, 6144, large block size in bits (k_size_6144=1)
K_SMALL, 1056, small block size in bits (k_size_6144=0)
IDX_W, 14, width of the bit-select index
SETTLE_CYC, 2, cycles between last byte load and first index (1..15)

Ports:
clk  in  1  system clock, all state on rising edge
clear_n  in  1  synchronous active-low reset
start  in  1  block request, sampled only in IDLE
k_size_6144  in  1  block size select, latched on accepted start
abort  in  1  synchronous abort, returns to IDLE next cycle
byte_valid  in  1  upstream byte present on shift-register input
byte_ready  out  1  controller accepts byte this cycle
shift_en  out  1  shift-register clock enable (= byte_valid & byte_ready)
k_sel  out  1  latched block size to remap and muxes
mux_ind  out  IDX_W  bit index driven to both output muxes
out_valid  out  1  outi/outpii currently valid for mux_ind
out_ready  in  1  downstream consumes the bit pair this cycle
out_last  out  1  out_valid & mux_ind==K-1
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last bit pair is consumed

Behaviour:
- Reset (clear_n=0 at clk edge): state IDLE. byte_ready=0, shift_en=0, k_sel=0, mux_ind=0, out_valid=0, out_last=0, busy=0, done=0. Byte and settle counters are 0. Reset overrides all other inputs, including mid-block.
- States: IDLE, LOAD, SETTLE, SERIAL, DONE.
- IDLE: if start=1, latch k_sel<=k_size_6144, clear byte_cnt, go to LOAD. Otherwise stay.
- LOAD: byte_ready=1. Each cycle with byte_valid=1, shift_en=1 and byte_cnt increments. When byte_cnt reaches K/8-1 (131 or 767) and a byte is accepted, go to SETTLE with settle_cnt=0. byte_valid=0 stalls the count.
- SETTLE: byte_ready=0. settle_cnt counts to SETTLE_CYC-1, then go to SERIAL with mux_ind=0.
- SERIAL: out_valid=1. mux_ind holds while out_ready=0. On out_ready=1, mux_ind increments. At mux_ind==K-1 with out_ready=1, go to DONE and clear mux_ind to 0.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. A start during DONE is ignored.
- K = K_LARGE when k_sel=1, else K_SMALL. Changes to k_size_6144 after start have no effect until the next accepted start.
- The counter does not wrap inside a block. It is 0 whenever out_valid=0.
- A start in any state other than IDLE is ignored (no queueing).
- abort=1 in LOAD, SETTLE, SERIAL or DONE: next state IDLE, all outputs return to reset values, no done pulse. The shift-register contents are not cleared; the next block overwrites them by loading a full K/8 bytes. If abort and clear_n=0 occur together, the reset result applies.
- Latency: start accepted at cycle 0. byte_ready=1 at cycle 1. The first out_valid comes SETTLE_CYC cycles after the cycle that accepts the last byte. With no stalls, a 1056-bit block takes 1+132+SETTLE_CYC+1056+1 cycles from start to return to IDLE.

Test Plan:
- Small block, no stalls: start with k_size_6144=0, byte_valid held 1, out_ready held 1 -> exactly 132 shift_en pulses; out_valid first rises 2 cycles after the last shift_en; mux_ind steps 0..1055; out_last=1 only at index 1055; done pulses once; return to IDLE.
- Large block with stalls: k_size_6144=1, byte_valid toggles 1/0, out_ready=0 for 3 cycles at mux_ind=100 -> 768 shift_en pulses; mux_ind holds at 100 for 3 cycles; last index 6143.
- Size change mid-block: start with k_size_6144=0, then drive 1 during LOAD -> k_sel stays 0; load stops at 132 bytes; output stops at 1055.
- Abort in SERIAL at mux_ind=500 -> next cycle IDLE, out_valid=0, mux_ind=0, no done; a new start runs a full clean block.
- Reset mid-LOAD (clear_n=0 after byte 40) -> all outputs at reset values next cycle; a start after release loads a full 132/768 bytes.
- Start asserted during busy and during DONE -> ignored; exactly one block is processed.

Source files
------------

// File: rtl/interleaver_seq_ctrl_if.sv
// Handshake and control bundle between the interleaver sequencer and its
// upstream byte source / downstream bit-pair consumer.
interface interleaver_seq_ctrl_if #(
    parameter int IDX_W = 14
);
    logic             start;
    logic             k_size_6144;
    logic             abort;
    logic             byte_valid;
    logic             byte_ready;
    logic             shift_en;
    logic             k_sel;
    logic [IDX_W-1:0] mux_ind;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic             done;

    modport master (
        output start, k_size_6144, abort, byte_valid, out_ready,
        input  byte_ready, shift_en, k_sel, mux_ind, out_valid, out_last, busy, done
    );

    modport slave (
        input  start, k_size_6144, abort, byte_valid, out_ready,
        output byte_ready, shift_en, k_sel, mux_ind, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/interleaver_seq_ctrl.sv
// Turbo interleaver sequencer: loads K/8 bytes, waits for the remap network to
// settle, then walks the shared bit-select index 0..K-1 under valid/ready.
module interleaver_seq_ctrl #(
    parameter int K_LARGE    = 6144,
    parameter int K_SMALL    = 1056,
    parameter int IDX_W      = 14,
    parameter int SETTLE_CYC = 2
) (
    input  logic                  clk,
    input  logic                  clear_n,
    interleaver_seq_ctrl_if.slave bus
);

    localparam int BCNT_W = IDX_W - 3;
    localparam logic [IDX_W-1:0]  LAST_IDX_L  = IDX_W'(K_LARGE - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX_S  = IDX_W'(K_SMALL - 1);
    localparam logic [BCNT_W-1:0] LAST_BYTE_L = BCNT_W'(K_LARGE / 8 - 1);
    localparam logic [BCNT_W-1:0] LAST_BYTE_S = BCNT_W'(K_SMALL / 8 - 1);
    localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_SERIAL,
        S_DONE
    } state_t;

    state_t            state, state_nx;
    logic              k_sel_q, k_sel_nx;
    logic [BCNT_W-1:0] byte_cnt, byte_cnt_nx;
    logic [3:0]        settle_cnt, settle_cnt_nx;
    logic [IDX_W-1:0]  mux_ind_q, mux_ind_nx;
    logic [IDX_W-1:0]  last_idx;
    logic [BCNT_W-1:0] last_byte;
    logic              byte_acc;
    logic              bit_acc;

    // Block geometry follows the latched size, never the live select input.
    assign last_idx  = k_sel_q ? LAST_IDX_L  : LAST_IDX_S;
    assign last_byte = k_sel_q ? LAST_BYTE_L : LAST_BYTE_S;
    assign byte_acc  = (state == S_LOAD)   && bus.byte_valid;
    assign bit_acc   = (state == S_SERIAL) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state      <= S_IDLE;
            k_sel_q    <= 1'b0;
            byte_cnt   <= '0;
            settle_cnt <= '0;
            mux_ind_q  <= '0;
        end else begin
            state      <= state_nx;
            k_sel_q    <= k_sel_nx;
            byte_cnt   <= byte_cnt_nx;
            settle_cnt <= settle_cnt_nx;
            mux_ind_q  <= mux_ind_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        k_sel_nx      = k_sel_q;
        byte_cnt_nx   = byte_cnt;
        settle_cnt_nx = settle_cnt;
        mux_ind_nx    = mux_ind_q;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    k_sel_nx    = bus.k_size_6144;
                    byte_cnt_nx = '0;
                    state_nx    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (byte_acc) begin
                    if (byte_cnt == last_byte) begin
                        byte_cnt_nx   = '0;
                        settle_cnt_nx = '0;
                        state_nx      = S_SETTLE;
                    end else begin
                        byte_cnt_nx = byte_cnt + 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_cnt_nx = '0;
                    mux_ind_nx    = '0;
                    state_nx      = S_SERIAL;
                end else begin
                    settle_cnt_nx = settle_cnt + 1'b1;
                end
            end
            S_SERIAL: begin
                if (bit_acc) begin
                    if (mux_ind_q == last_idx) begin
                        mux_ind_nx = '0;
                        state_nx   = S_DONE;
                    end else begin
                        mux_ind_nx = mux_ind_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Abort drops the block outright; shift-register contents are left for
        // the next full load to overwrite.
        if (bus.abort && (state != S_IDLE)) begin
            state_nx      = S_IDLE;
            k_sel_nx      = 1'b0;
            byte_cnt_nx   = '0;
            settle_cnt_nx = '0;
            mux_ind_nx    = '0;
        end
    end

    assign bus.byte_ready = (state == S_LOAD);
    assign bus.shift_en   = byte_acc;
    assign bus.k_sel      = k_sel_q;
    assign bus.mux_ind    = mux_ind_q;
    assign bus.out_valid  = (state == S_SERIAL);
    assign bus.out_last   = (state == S_SERIAL) && (mux_ind_q == last_idx);
    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = (state == S_DONE);

endmodule
